// File: rtl/midi_cmd_encoder.sv
// MIDI byte stream to 16-bit bank-manager command words.
// Parses running status, skips real-time and SysEx bytes, and queues Note On/Off and STOP_ALL words in a FIFO.
module midi_cmd_encoder #(
  parameter int CHANNEL    = 0,
  parameter int OMNI       = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  input  logic        i_ready,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_overflow
);

  // state | meaning
  // IDLE  | no running status; data bytes ignored
  // D1    | running status held, expecting first data byte
  // D2    | first data byte captured, expecting second
  // SYSEX | inside a system exclusive dump; data bytes ignored
  typedef enum logic [1:0] {IDLE, D1, D2, SYSEX} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] CH = 4'(CHANNEL);
  localparam logic OMNI_EN = (OMNI != 0);

  state_t      state, state_next;
  logic [7:0]  status, status_next;
  logic [6:0]  d1, d1_next;
  logic        cand_valid;
  logic [15:0] cand_word;
  logic        push_q;
  logic [15:0] push_word_q;

  logic [3:0]  msg_type;
  logic [6:0]  vel;
  logic        chan_ok;
  logic        note_ok;

  assign msg_type = status[7:4];
  assign vel      = i_byte[6:0];
  assign chan_ok  = OMNI_EN || (status[3:0] == CH);
  // note 0 is the consumer's free-slot marker; 127 as an off collides with STOP_ALL
  assign note_ok  = (d1 != 7'd0) && (d1 != 7'h7F);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      status      <= '0;
      d1          <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      state       <= state_next;
      status      <= status_next;
      d1          <= d1_next;
      push_q      <= cand_valid;
      push_word_q <= cand_word;
    end
  end

  always_comb begin
    state_next  = state;
    status_next = status;
    d1_next     = d1;
    cand_valid  = 1'b0;
    cand_word   = '0;
    if (i_byte_valid && (i_byte[7:3] != 5'b11111)) begin
      if (i_byte == 8'hF0) begin
        state_next  = SYSEX;
        status_next = '0;
      end else if (i_byte[7:4] == 4'hF) begin
        state_next  = IDLE;
        status_next = '0;
      end else if (i_byte[7]) begin
        status_next = i_byte;
        state_next  = D1;
      end else begin
        case (state)
          D1: begin
            if (msg_type == 4'hC || msg_type == 4'hD) begin
              state_next = D1;
            end else begin
              d1_next    = i_byte[6:0];
              state_next = D2;
            end
          end
          D2: begin
            state_next = D1;
            if (chan_ok) begin
              case (msg_type)
                4'h9: begin
                  cand_valid = note_ok;
                  cand_word  = (vel != 7'd0) ? {1'b1, d1, 1'b0, vel} : {1'b0, d1, 8'h00};
                end
                4'h8: begin
                  cand_valid = note_ok;
                  cand_word  = {1'b0, d1, 1'b0, vel};
                end
                4'hB: begin
                  cand_valid = (d1 == 7'd120) || (d1 == 7'd123);
                  cand_word  = 16'h7F00;
                end
                default: cand_valid = 1'b0;
              endcase
            end
          end
          default: state_next = state;
        endcase
      end
    end
  end

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;

  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign do_pop    = (count != '0) && i_ready;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push   = push_q && (!fifo_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count + CW'(do_push) - CW'(do_pop);
      o_valid    <= do_pop;
      o_data     <= do_pop ? mem[rd_ptr] : 16'h0000;
      o_overflow <= push_q && !do_push;
    end
  end

endmodule
